// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StCheck,
    StDone,
    StError
  } boot_state_t;

  localparam logic [7:0]  BOOT_SYNC            = 8'hA5;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/boot_loader_uart_rx.sv
// 8N1 UART receiver: synchronised input, centre sampling, one-cycle byte strobe.
module uart_rx
  import boot_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;

  rx_state_t       state_q;
  logic            sync1_q, sync2_q, prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            valid_q, ferr_q;
  logic [7:0]      data_q;

  // Synchroniser and edge-history flops idle high so reset never looks like a start bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          if (!sync2_q && prev_q) begin
            state_q <= RxStart;
            cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (cnt_q == HalfCnt) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == FullCnt) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RxStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == FullCnt) begin
            cnt_q   <= '0;
            valid_q <= 1'b1;
            ferr_q  <= !sync2_q;
            data_q  <= shift_q;
            state_q <= RxIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/boot_loader.sv
// UART boot loader: parses sync/length/data/checksum frames into instruction memory writes.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rx,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              im_we,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK        (CLK),
    .RST        (RST),
    .rx         (rx),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_ferr)
  );

  boot_state_t       state_q, state_d;
  logic [7:0]        len_hi_q, hi_q, csum_q;
  logic [ADDR_W:0]   len_q, wc_q, wc_inc;
  logic              inc_pend_q;
  logic [15:0]       n_words;
  logic              loading;
  logic              we_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign n_words = {len_hi_q, rx_data};
  assign wc_inc  = wc_q + (ADDR_W + 1)'(1);
  assign loading = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StCheck};

  always_comb begin
    state_d = state_q;
    if (inc_pend_q) begin
      state_d = (wc_inc == len_q) ? StCheck : StDataHi;
    end else if (rx_valid && rx_ferr) begin
      // Framing errors abort an active load; outside a load the byte is just dropped.
      if (loading) state_d = StError;
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle, StDone, StError: if (rx_data == BOOT_SYNC) state_d = StLenHi;
        StLenHi:  state_d = StLenLo;
        StLenLo: begin
          if (n_words == 16'd0)                state_d = StCheck;
          else if ({1'b0, n_words} > MaxWords) state_d = StError;
          else                                 state_d = StDataHi;
        end
        StDataHi: state_d = StDataLo;
        StDataLo: state_d = StDataLo;
        StCheck:  state_d = (rx_data == csum_q) ? StDone : StError;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      len_hi_q   <= '0;
      hi_q       <= '0;
      csum_q     <= '0;
      len_q      <= '0;
      wc_q       <= '0;
      inc_pend_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;
      if (rx_valid && !rx_ferr) begin
        unique case (state_q)
          StIdle, StDone, StError: begin
            if (rx_data == BOOT_SYNC) begin
              wc_q   <= '0;
              csum_q <= '0;
            end
          end
          StLenHi: begin
            len_hi_q <= rx_data;
            csum_q   <= csum_q ^ rx_data;
          end
          StLenLo: begin
            len_q  <= n_words[ADDR_W:0];
            csum_q <= csum_q ^ rx_data;
          end
          StDataHi: begin
            hi_q   <= rx_data;
            csum_q <= csum_q ^ rx_data;
          end
          StDataLo: begin
            csum_q     <= csum_q ^ rx_data;
            we_q       <= 1'b1;
            addr_q     <= wc_q[ADDR_W-1:0];
            wdata_q    <= DATA_W'({hi_q, rx_data});
            inc_pend_q <= 1'b1;
          end
          default: ;
        endcase
      end
      // Count advances the cycle the write strobe is visible.
      if (inc_pend_q) begin
        wc_q       <= wc_inc;
        inc_pend_q <= 1'b0;
      end
      busy_q <= state_d inside {StLenHi, StLenLo, StDataHi, StDataLo, StCheck};
      done_q <= state_d == StDone;
      err_q  <= state_d == StError;
    end
  end

  assign im_we      = we_q;
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign word_count = wc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_rst_n  = done_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: framed loads, checksum/length/framing errors, reset, glitch.
module tb_boot_loader;

  localparam int unsigned Cpb = 16;
  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          rx  = 1'b1;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_wdata;
  logic          im_we, cpu_rst_n, busy, done, err;
  logic [AW:0]   word_count;

  boot_loader #(.CLKS_PER_BIT(Cpb), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .rx         (rx),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .im_we      (im_we),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            we_wide = 0;
  int            strobes = 0;
  logic          we_prev = 1'b0;
  logic [7:0]    tx_q[$];

  always @(negedge CLK) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
      if (we_prev) we_wide++;
    end
    we_prev = im_we;
    if (dut.rx_valid) strobes++;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (Cpb) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(posedge CLK);
    end
    rx = stop;
    repeat (Cpb) @(posedge CLK);
    rx = 1'b1;
    if (!stop) repeat (Cpb) @(posedge CLK);
  endtask

  task automatic send_q();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    tx_q.delete();
    repeat (4) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    we_wide = 0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({im_we, im_addr, im_wdata, word_count, busy, done, err, cpu_rst_n} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b addr=%h wd=%h wc=%0d busy=%b done=%b err=%b cpu=%b, want all 0",
               im_we, im_addr, im_wdata, word_count, busy, done, err, cpu_rst_n);
    end
    RST = 1'b1;
    repeat (3) @(posedge CLK);
  endtask

  task automatic test_glitch();
    int s0;
    s0 = strobes;
    rx = 1'b0;
    repeat (Cpb / 4) @(posedge CLK);
    rx = 1'b1;
    repeat (3 * Cpb) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (strobes !== s0) begin
      miscompares++;
      $display("FAIL glitch_strobe: got %0d strobes, want %0d", strobes, s0);
    end
    vectors++;
    if ({busy, done, err} !== 3'b000) begin
      miscompares++;
      $display("FAIL glitch_idle: got busy/done/err=%b, want 000", {busy, done, err});
    end
  endtask

  // XOR(00,02,12,34,AB,CD) = 42
  task automatic test_good_frame();
    clear_log();
    tx_q = '{8'hA5};
    send_q();
    vectors++;
    if ({busy, cpu_rst_n} !== 2'b10) begin
      miscompares++;
      $display("FAIL sync_busy: got busy=%b cpu=%b, want busy=1 cpu=0", busy, cpu_rst_n);
    end
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    send_q();
    vectors++;
    if (wr_addr.size() !== 2) begin
      miscompares++;
      $display("FAIL good_wr_count: got %0d, want 2", wr_addr.size());
    end else begin
      vectors++;
      if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {10'd0, 16'h1234, 10'd1, 16'hABCD}) begin
        miscompares++;
        $display("FAIL good_wr_content: got %h@%0d %h@%0d, want 1234@0 abcd@1",
                 wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
      end
    end
    vectors++;
    if ({word_count, done, err, busy, cpu_rst_n} !== {11'd2, 4'b1001}) begin
      miscompares++;
      $display("FAIL good_status: got wc=%0d done=%b err=%b busy=%b cpu=%b, want wc=2 done=1 err=0 busy=0 cpu=1",
               word_count, done, err, busy, cpu_rst_n);
    end
    vectors++;
    if (we_wide !== 0) begin
      miscompares++;
      $display("FAIL we_width: got %0d multi-cycle strobes, want 0", we_wide);
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_q();
    vectors++;
    if (wr_addr.size() !== 2) begin
      miscompares++;
      $display("FAIL badcs_wr_count: got %0d, want 2", wr_addr.size());
    end
    vectors++;
    if ({done, err, cpu_rst_n} !== 3'b010) begin
      miscompares++;
      $display("FAIL badcs_status: got done/err/cpu=%b, want 010", {done, err, cpu_rst_n});
    end
  endtask

  task automatic test_zero_and_oversize();
    clear_log();
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    vectors++;
    if ({wr_addr.size() == 0, word_count, done, err, cpu_rst_n} !== {1'b1, 11'd0, 3'b101}) begin
      miscompares++;
      $display("FAIL zero_len: got writes=%0d wc=%0d done=%b err=%b cpu=%b, want 0 0 1 0 1",
               wr_addr.size(), word_count, done, err, cpu_rst_n);
    end
    tx_q = '{8'hA5, 8'h04, 8'h01};
    send_q();
    vectors++;
    if ({done, err, busy, cpu_rst_n} !== 4'b0100) begin
      miscompares++;
      $display("FAIL oversize: got done/err/busy/cpu=%b, want 0100", {done, err, busy, cpu_rst_n});
    end
  endtask

  task automatic test_frame_err();
    clear_log();
    tx_q = '{8'hA5, 8'h00, 8'h02};
    send_q();
    send_byte(8'h12, 1'b0);
    tx_q = '{8'h34, 8'hAB, 8'hCD, 8'h42};
    send_q();
    vectors++;
    if ({wr_addr.size() == 0, done, err} !== 3'b101) begin
      miscompares++;
      $display("FAIL frame_err: got writes=%0d done=%b err=%b, want 0 0 1", wr_addr.size(), done, err);
    end
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    send_q();
    vectors++;
    if ({wr_addr.size() == 2, done, err} !== 3'b110) begin
      miscompares++;
      $display("FAIL frame_err_recover: got writes=%0d done=%b err=%b, want 2 1 0", wr_addr.size(), done, err);
    end
  endtask

  // XOR(00,02,DE,AD,BE,EF) = 20
  task automatic test_reset_midload();
    clear_log();
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
    send_q();
    vectors++;
    if ({wr_addr.size() == 1, word_count} !== {1'b1, 11'd1}) begin
      miscompares++;
      $display("FAIL midload_first_word: got writes=%0d wc=%0d, want 1 1", wr_addr.size(), word_count);
    end
    #2 RST = 1'b0;
    #1;
    vectors++;
    if ({im_we, im_addr, im_wdata, word_count, busy, done, err, cpu_rst_n} !== '0) begin
      miscompares++;
      $display("FAIL midload_reset: got we=%b addr=%h wd=%h wc=%0d busy=%b done=%b err=%b cpu=%b, want all 0",
               im_we, im_addr, im_wdata, word_count, busy, done, err, cpu_rst_n);
    end
    repeat (2) @(posedge CLK);
    RST = 1'b1;
    clear_log();
    tx_q = '{8'hAB, 8'hCD, 8'h42};
    send_q();
    vectors++;
    if (wr_addr.size() !== 0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: got %0d writes, want 0", wr_addr.size());
    end
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h20};
    send_q();
    vectors++;
    if (wr_addr.size() !== 2) begin
      miscompares++;
      $display("FAIL reload_wr_count: got %0d, want 2", wr_addr.size());
    end else begin
      vectors++;
      if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]} !== {10'd0, 16'hDEAD, 10'd1, 16'hBEEF}) begin
        miscompares++;
        $display("FAIL reload_content: got %h@%0d %h@%0d, want dead@0 beef@1",
                 wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
      end
    end
    vectors++;
    if ({word_count, done, cpu_rst_n} !== {11'd2, 2'b11}) begin
      miscompares++;
      $display("FAIL reload_status: got wc=%0d done=%b cpu=%b, want 2 1 1", word_count, done, cpu_rst_n);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_good_frame();
    test_bad_checksum();
    test_zero_and_oversize();
    test_frame_err();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
